// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory stage bus: upstream entry fields, downstream entry fields,
// branch resolution and forwarding taps.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              zero_flag;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  dest_reg;
  logic              mem_read;
  logic              mem_write;
  logic              reg_write;
  logic              branch;
  logic              branch_ne;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] branch_offset;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_dest_reg;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_reg_write;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_reg;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, alu_result, zero_flag, store_data, dest_reg,
           mem_read, mem_write, reg_write, branch, branch_ne,
           pc_plus4, branch_offset, flush, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_dest_reg,
           out_mem_read, out_mem_write, out_reg_write, branch_taken,
           branch_target, fwd_valid, fwd_reg, fwd_data
  );

  modport slave (
    input  in_valid, alu_result, zero_flag, store_data, dest_reg,
           mem_read, mem_write, reg_write, branch, branch_ne,
           pc_plus4, branch_offset, flush, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_dest_reg,
           out_mem_read, out_mem_write, out_reg_write, branch_taken,
           branch_target, fwd_valid, fwd_reg, fwd_data
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer, branch resolution at
// accept time, and a forwarding tap from the main entry.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store;
    logic [REG_W-1:0]  dest;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } entry_t;

  entry_t            w_in_entry;
  entry_t            r_main;
  entry_t            r_skid;
  entry_t            w_main_nxt;
  entry_t            w_skid_nxt;
  logic              r_main_valid;
  logic              r_skid_valid;
  logic              w_main_valid_nxt;
  logic              w_skid_valid_nxt;
  logic              r_in_ready;
  logic              r_br_taken;
  logic [DATA_W-1:0] r_br_target;
  logic              w_accept;
  logic              w_drain;
  logic              w_taken;
  logic [DATA_W-1:0] w_target;

  assign w_in_entry = {bus.alu_result, bus.store_data, bus.dest_reg,
                       bus.mem_read, bus.mem_write, bus.reg_write};
  assign w_accept   = bus.in_valid & r_in_ready & ~bus.flush;
  assign w_drain    = r_main_valid & bus.out_ready;
  assign w_taken    = bus.branch & (bus.zero_flag ^ bus.branch_ne);
  assign w_target   = bus.pc_plus4 + (bus.branch_offset << 2'd2);

  // Next-state selection for main and skid entries
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (bus.flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid || w_drain) begin
      // Skid always refills main first so ordering is preserved.
      if (r_skid_valid) begin
        w_main_nxt       = r_skid;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_nxt       = w_in_entry;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_nxt       = w_in_entry;
      w_skid_valid_nxt = 1'b1;
    end else begin
      w_skid_valid_nxt = r_skid_valid;
    end
  end

  // Entry storage, registered ready and branch outcome
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_br_taken   <= 1'b0;
      r_br_target  <= {DATA_W{1'b0}};
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      r_br_taken   <= w_accept & w_taken;
      if (w_accept && bus.branch) begin
        r_br_target <= w_target;
      end
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = r_main_valid;
  assign bus.out_result     = r_main.result;
  assign bus.out_store_data = r_main.store;
  assign bus.out_dest_reg   = r_main.dest;
  assign bus.out_mem_read   = r_main.mem_read;
  assign bus.out_mem_write  = r_main.mem_write;
  assign bus.out_reg_write  = r_main.reg_write;
  assign bus.branch_taken   = r_br_taken;
  assign bus.branch_target  = r_br_target;
  assign bus.fwd_valid      = r_main_valid & r_main.reg_write & (r_main.dest != {REG_W{1'b0}});
  assign bus.fwd_reg        = r_main.dest;
  assign bus.fwd_data       = r_main.result;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline stage directly downstream of the ALU. It captures each ALU result and zero flag together with the memory and write-back control fields, and resolves conditional branches. It presents the captured entry to the memory stage through a valid/ready handshake. A two-entry skid buffer lets the execute stage keep issuing for one cycle after the memory stage stalls.

## Interface
- Parameters:
- DATA_W, 32, width of ALU result, store data and PC values
- REG_W, 5, width of destination register index
- Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; equals NOT skid_full
- alu_result  in  DATA_W  ALU result
- zero_flag  in  1  ALU zero flag
- store_data  in  DATA_W  data for memory write
- dest_reg  in  REG_W  write-back register index
- mem_read, mem_write, reg_write  in  1 each  control fields
- branch  in  1  entry is a conditional branch
- branch_ne  in  1  1 = BNE semantics, 0 = BEQ
- pc_plus4  in  DATA_W  address of the following instruction
- branch_offset  in  DATA_W  sign-extended word offset
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  main entry valid
- out_ready  in  1  memory stage accepts
- out_result, out_store_data  out  DATA_W  from main entry
- out_dest_reg  out  REG_W  from main entry
- out_mem_read, out_mem_write, out_reg_write  out  1 each  from main entry
- branch_taken  out  1  one-cycle pulse
- branch_target  out  DATA_W  valid while branch_taken=1
- fwd_valid  out  1  out_valid AND out_reg_write AND out_dest_reg≠0
- fwd_reg  out  REG_W  equals out_dest_reg
- fwd_data  out  DATA_W  equals out_result

## Operation
- Storage: main entry (drives the out_* ports) and skid entry. Each entry holds result, store_data, dest_reg and the three control bits.
- Accept: accept = in_valid AND in_ready AND NOT flush.
- Drain: drain = out_valid AND out_ready.
- Main entry update, by case:
  - main empty or draining, skid full: main ← skid, skid emptied.
  - main empty or draining, skid empty: main ← accepted input, or becomes empty if none.
  - main full, not draining, accept: skid ← input.
- Drain and accept in the same cycle with skid empty: the input passes into main and skid stays empty.
- in_ready is registered and equals NOT skid_full, so the stage never drops an accepted entry.
- Branch resolution happens at accept time and does not depend on downstream backpressure:
  - taken = branch AND (zero_flag XOR branch_ne)
  - branch_target = pc_plus4 + (branch_offset << 2), truncated to DATA_W; wraps modulo 2^DATA_W.
- Branch entries still propagate as normal entries.
- flush has priority over everything:
  - Next cycle, main and skid are empty, out_valid=0 and in_ready=1.
  - Same-cycle input is not accepted and branch_taken does not pulse for it.
  - A drain in the flush cycle still completes.
- Reset mid-operation discards all entries immediately and asynchronously.

## Timing
- Reset values: out_valid=0, in_ready=1, branch_taken=0, fwd_valid=0, and all data, control, branch_target and fwd outputs are 0.
- Latency: an entry accepted at edge N is on out_* after edge N, when main was empty or draining.
- A branch accepted at edge N asserts branch_taken for exactly the cycle following edge N. branch_target is registered in the same cycle.
- out_* hold stable while out_valid=1 and out_ready=0.
- in_ready falls the cycle after the skid fills. It rises the cycle after the skid empties.
- Throughput: one entry per cycle while out_ready=1.

## Test plan
- Reset then single entry: alu_result=3, reg_write=1, dest_reg=5, out_ready=1 → out_valid=1 one cycle later with out_result=3, fwd_valid=1, fwd_reg=5.
- Backpressure: out_ready=0, issue results 1, 2 → in_ready=0 after the second; third input 3 held off. Raise out_ready → outputs 1, 2, 3 in order, no loss or duplication.
- BEQ taken: zero_flag=1, branch=1, branch_ne=0, pc_plus4=0x100, branch_offset=4 → branch_taken pulse, branch_target=0x110.
- BNE not taken: zero_flag=1, branch_ne=1 → branch_taken stays 0.
- Wrap and negative offset:
  - pc_plus4=0x4, branch_offset=0xFFFFFFFE, BEQ with zero_flag=1 → branch_target=0xFFFFFFFC.
  - pc_plus4=0xFFFFFFFC, branch_offset=2 → branch_target=0x4.
- Flush with both entries full, plus rst_n pulled low mid-stream → out_valid=0 and in_ready=1 the next cycle (immediately for reset). No pulse for the flushed-cycle branch.
